// File: rtl/fetch_pkg.sv
// Shared types, constants and helpers for the decoupled instruction-fetch front end.
package fetch_pkg;
    localparam int FETCH_XLEN  = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [FETCH_XLEN-1:0] NOP_INSTR = 32'h0;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] inst;
        logic [FETCH_XLEN-1:0] pc4;
    } fetch_entry_t;

    // Bits needed to hold any value 0..n inclusive; never less than one.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: DEPTH entries with push/pop/flush and a registered head that
// holds its last value when the FIFO drains or is flushed.
module fetch_fifo import fetch_pkg::*; #(
    parameter int                 WIDTH    = 64,
    parameter int                 DEPTH    = 4,
    parameter logic [WIDTH-1:0]   HEAD_RST = '0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          push_i,
    input  logic [WIDTH-1:0]              wdata_i,
    input  logic                          pop_i,
    output logic [WIDTH-1:0]              head_o,
    output logic [cnt_width(DEPTH)-1:0]   count_o,
    output logic                          empty_o
);
    localparam int CW = cnt_width(DEPTH);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop, full;

    assign rd_nxt  = rd_ptr_q + 1'b1;
    assign full    = (count_q == CW'(DEPTH));
    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !flush_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_nxt;
            count_d = count_q + CW'(do_push) - CW'(do_pop);
            // Head follows the next live entry; an incoming word becomes head only
            // when nothing older remains after this cycle's pop.
            if (do_pop && count_q > CW'(1))
                head_d = mem_q[rd_nxt];
            else if (do_push && (count_q == '0 || (do_pop && count_q == CW'(1))))
                head_d = wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= HEAD_RST;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign head_o  = head_q;
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(do_push && full));
endmodule

// File: rtl/fetch_unit.sv
// Decoupled fetch front end: credit-limited imem requests, in-order responses into a
// prefetch FIFO, redirect with stale-response dropping. FETCH_PERF_EN adds perf counters.
module fetch_unit import fetch_pkg::*; #(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            inst_valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc4_o,
    input  logic            inst_ready_i
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_stall_cnt_o,
    output logic [31:0]     perf_flush_cnt_o
`endif
);
    localparam int              CW   = cnt_width(DEPTH);
    localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, target;
    logic [CW-1:0]     outst_q, outst_d, drop_q, drop_d, fifo_count;
    logic [CW:0]       inflight;
    logic [2*XLEN-1:0] fifo_head;
    logic              fifo_empty, issue, push, pop;

    assign target      = redirect_pc_i & ~XLEN'(3);
    assign inflight    = {1'b0, fifo_count} + {1'b0, outst_q};
    assign imem_req_o  = !rst_i && !redirect_i && (inflight < (CW+1)'(DEPTH));
    assign imem_addr_o = fetch_pc_q;
    assign issue       = imem_req_o && imem_gnt_i;
    assign push        = !rst_i && !redirect_i && imem_rvalid_i && (drop_q == '0);

    assign inst_valid_o = !rst_i && !fifo_empty && !redirect_i;
    assign pop          = inst_valid_o && inst_ready_i;
    assign {inst_o, inst_pc4_o} = fifo_head;

    fetch_fifo #(
        .WIDTH    (2*XLEN),
        .DEPTH    (DEPTH),
        .HEAD_RST ({XLEN'(NOP_INSTR), {XLEN{1'b0}}})
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .push_i  (push),
        .wdata_i ({imem_rdata_i, resp_pc_q + STEP}),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        if (redirect_i) begin
            // Everything still in flight is stale, including a response landing now.
            fetch_pc_d = target;
            resp_pc_d  = target;
            outst_d    = outst_q - CW'(imem_rvalid_i);
            drop_d     = outst_q - CW'(imem_rvalid_i);
        end else begin
            if (issue) fetch_pc_d = fetch_pc_q + STEP;
            outst_d = outst_q + CW'(issue) - CW'(imem_rvalid_i);
            if (imem_rvalid_i) begin
                if (drop_q != '0) drop_d    = drop_q - 1'b1;
                else              resp_pc_d = resp_pc_q + STEP;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    // A response with nothing in flight means memory did not observe our reset.
    a_rvalid_has_req: assert property (@(posedge clk_i) disable iff (rst_i)
        imem_rvalid_i |-> (outst_q != '0));

`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (inst_valid_o && !inst_ready_i && perf_stall_q != '1)
                perf_stall_q <= perf_stall_q + 32'd1;
            if (redirect_i && perf_flush_q != '1)
                perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign perf_stall_cnt_o = perf_stall_q;
    assign perf_flush_cnt_o = perf_flush_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a latency-programmable memory model, directed
// scenarios pushing expected {inst, pc4} entries, and a decoupled output monitor.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] KEY = 32'h1234_5678;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc4_o;
    logic        inst_ready_i = 1'b0;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cnt_o, perf_flush_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_pc4_o    (inst_pc4_o),
        .inst_ready_i  (inst_ready_i)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cnt_o (perf_stall_cnt_o),
        .perf_flush_cnt_o (perf_flush_cnt_o)
`endif
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;

    mreq_t        pending[$];
    logic [31:0]  gnt_log[$];
    int           gnt_cyc[$];
    int           hs_cyc[$];
    fetch_entry_t exp_q[$];
    int cyc = 0, lat = 1, want = 0, total = 0, passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    function automatic logic [31:0] glog(input int i);
        if (i < gnt_log.size()) return gnt_log[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic int gcyc(input int i);
        if (i < gnt_cyc.size()) return gnt_cyc[i];
        return -100;
    endfunction

    function automatic int hsc(input int i);
        if (i < hs_cyc.size()) return hs_cyc[i];
        return -100;
    endfunction

    always @(posedge clk_i) cyc <= cyc + 1;

    // Memory: record grants seen just before the edge, deliver in order after lat cycles.
    always @(negedge clk_i) begin
        mreq_t m;
        if (!rst_i && imem_req_o && imem_gnt_i) begin
            m.addr = imem_addr_o;
            m.due  = cyc + lat;
            pending.push_back(m);
            gnt_log.push_back(imem_addr_o);
            gnt_cyc.push_back(cyc);
        end
    end

    always @(posedge clk_i) begin
        #1;
        imem_rvalid_i = 1'b0;
        if (rst_i) pending.delete();
        else if (pending.size() > 0 && pending[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = pending[0].addr ^ KEY;
            void'(pending.pop_front());
        end
        inst_ready_i = (want > 0);
    end

    // Monitor: every IF/ID handshake is checked against the scoreboard head.
    always @(negedge clk_i) begin
        fetch_entry_t e;
        if (!rst_i && inst_valid_o && inst_ready_i) begin
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_out: got inst=%h pc4=%h, none expected", inst_o, inst_pc4_o);
            end else begin
                e = exp_q.pop_front();
                chk("out", {inst_o, inst_pc4_o}, e);
            end
            if (want > 0) want--;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic exp_seq(input logic [31:0] pc, input int n);
        fetch_entry_t e;
        for (int i = 0; i < n; i++) begin
            e.inst = pc ^ KEY;
            e.pc4  = pc + 32'd4;
            exp_q.push_back(e);
            pc = pc + 32'd4;
        end
    endtask

    task automatic exp_raw(input logic [31:0] inst, input logic [31:0] pc4);
        fetch_entry_t e;
        e.inst = inst;
        e.pc4  = pc4;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst_i = 1'b1; redirect_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
        want = 0; inst_ready_i = 1'b0;
        pending.delete(); exp_q.delete();
        tick(1);
        chk("rst_req",   imem_req_o,   0);
        chk("rst_valid", inst_valid_o, 0);
        chk("rst_inst",  inst_o,       0);
        chk("rst_pc4",   inst_pc4_o,   0);
        tick(1);
        gnt_log.delete(); gnt_cyc.delete(); hs_cyc.delete();
    endtask

    task automatic wait_done(input string name, input int max);
        int n = 0;
        while (want > 0 && n < max) begin
            @(posedge clk_i);
            n++;
        end
        #1;
        chk(name, want, 0);
        chk({name, "_sb"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Zero-wait memory, always ready: back-to-back issue and output.
        do_reset();
        lat = 1; imem_gnt_i = 1'b1; exp_seq(32'h0, 3); want = 3;
        rst_i = 1'b0;
        wait_done("t1_drain", 40);
        chk("t1_addr0", glog(0), 32'h0);
        chk("t1_addr1", glog(1), 32'h4);
        chk("t1_addr2", glog(2), 32'h8);
        chk("t1_issue_gap01", gcyc(1) - gcyc(0), 1);
        chk("t1_issue_gap12", gcyc(2) - gcyc(1), 1);
        chk("t1_out_gap01", hsc(1) - hsc(0), 1);
        chk("t1_out_gap12", hsc(2) - hsc(1), 1);

        // Back-pressure: credits cap grants at DEPTH, then drain and resume.
        do_reset();
        lat = 1; imem_gnt_i = 1'b1;
        rst_i = 1'b0;
        tick(10);
        chk("t2_grants", gnt_log.size(), 4);
        chk("t2_req_low", imem_req_o, 0);
        exp_seq(32'h0, 4); want = 4;
        wait_done("t2_drain", 40);
        tick(3);
        chk("t2_resume", glog(4), 32'h10);

        // Latency 3, two in flight, redirect: both stale responses dropped.
        do_reset();
        lat = 3; imem_gnt_i = 1'b1;
        rst_i = 1'b0;
        tick(2);
        redirect_i = 1'b1; redirect_pc_i = 32'h100;
        exp_seq(32'h100, 2); want = 2;
        tick(1);
        redirect_i = 1'b0;
        wait_done("t3_drain", 40);
        chk("t3_addr_redir", glog(2), 32'h100);

        // Redirect coinciding with the only outstanding response.
        do_reset();
        lat = 2; imem_gnt_i = 1'b1;
        rst_i = 1'b0;
        tick(1);
        imem_gnt_i = 1'b0;
        tick(1);
        redirect_i = 1'b1; redirect_pc_i = 32'h200; imem_gnt_i = 1'b1;
        exp_seq(32'h200, 1); want = 1;
        tick(1);
        redirect_i = 1'b0;
        wait_done("t4_drain", 40);
        chk("t4_addr_redir", glog(1), 32'h200);

        // Redirect to the top of the address space (low bits set): PC wraps.
        do_reset();
        lat = 1; imem_gnt_i = 1'b0;
        rst_i = 1'b0;
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF; imem_gnt_i = 1'b1;
        exp_raw(32'hEDCB_A984, 32'h0000_0000);
        exp_raw(32'h1234_5678, 32'h0000_0004);
        want = 2;
        tick(1);
        redirect_i = 1'b0;
        wait_done("t5_drain", 40);
        chk("t5_addr_top",  glog(0), 32'hFFFF_FFFC);
        chk("t5_addr_wrap", glog(1), 32'h0000_0000);

        // Reset with FIFO half full and requests in flight.
        do_reset();
        lat = 1; imem_gnt_i = 1'b1;
        rst_i = 1'b0;
        tick(2);
        imem_gnt_i = 1'b0;
        tick(2);
        lat = 10; imem_gnt_i = 1'b1;
        tick(2);
        imem_gnt_i = 1'b0;
        chk("t6_fifo_valid", inst_valid_o, 1);
        chk("t6_credit_full", imem_req_o, 0);
        do_reset();
        lat = 1; imem_gnt_i = 1'b1; exp_seq(32'h0, 1); want = 1;
        rst_i = 1'b0;
        wait_done("t6_drain", 40);
        chk("t6_first_addr", glog(0), 32'h0);

        tick(2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised, decoupled instruction-fetch front end for the 5-stage MIPS pipeline. It replaces the bare PC register, PC+4 adder and direct instruction-memory read.
- Issues pipelined requests to an instruction memory with variable latency and buffers responses in a DEPTH-entry prefetch FIFO.
- Presents {instruction, PC+4} to IF/ID over a valid/ready handshake.
- Handles branch/jump redirects from ID, including discarding in-flight stale responses.

Parameters:
- XLEN, 32, address/data width.
- DEPTH, 4, max instructions buffered plus outstanding; power of two, ≥2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  XLEN  fetch address, word aligned
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response valid; responses return in request order
- imem_rdata_i  in  XLEN  instruction word
- redirect_i  in  1  taken branch/jump from ID
- redirect_pc_i  in  XLEN  target; bits [1:0] ignored, treated as 00
- inst_valid_o  out  1  FIFO head valid
- inst_o  out  XLEN  head instruction
- inst_pc4_o  out  XLEN  head address + 4
- inst_ready_i  in  1  IF/ID accepts (IFIDWrite)

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset state: fetch_pc=RESET_PC, resp_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0.
- Reset outputs: imem_req_o=0, inst_valid_o=0, inst_o=0, inst_pc4_o=0.
- Reset mid-operation: discards everything. Instruction memory shares rst_i; a response after reset is a protocol violation and gets an assertion.
- Counter widths: outstanding and drop_cnt are $clog2(DEPTH+1) bits. outstanding counts every in-flight request, including ones marked for drop.
- Issue rule: imem_req_o = !redirect_i && (fifo_count + outstanding < DEPTH).
  - imem_addr_o = fetch_pc.
  - On req && gnt: fetch_pc += 4 (mod 2^XLEN, wraps silently); outstanding++.
  - imem_req_o/addr stay stable until gnt unless redirect_i or rst_i.
- Response rule: on rvalid, outstanding--.
  - If drop_cnt > 0: drop_cnt--, data discarded.
  - Otherwise: push {rdata, resp_pc+4}; resp_pc += 4.
  - Simultaneous issue and response: net outstanding is unchanged.
- Output: inst_valid_o = !fifo_empty && !redirect_i. inst_o/inst_pc4_o come from the FIFO head (registered).
  - Pop when inst_valid_o && inst_ready_i.
  - Latency: rvalid into an empty FIFO → inst_valid_o on the next cycle. No combinational rdata→inst_o path.
- Redirect (highest priority after reset), in the cycle redirect_i=1:
  - FIFO flushed; no pop; no issue.
  - fetch_pc ← redirect_pc, resp_pc ← redirect_pc.
  - drop_cnt ← outstanding − (imem_rvalid_i ? 1 : 0); the same-cycle response is discarded.
- Back-to-back redirects: each recomputes drop_cnt from current outstanding.
- Full: the credit rule guarantees no push into a full FIFO; assert this.
- Empty: inst_valid_o=0; outputs hold their last value.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined:
  - Adds outputs perf_stall_cnt_o (32) and perf_flush_cnt_o (32), both 0 on reset, saturating.
  - perf_stall_cnt_o counts cycles with inst_valid_o && !inst_ready_i.
  - perf_flush_cnt_o counts redirect_i cycles.
- When undefined: ports and logic are absent; functional behaviour is identical.

Decomposition:
- Package fetch_pkg:
  - INSTR_BYTES=4.
  - NOP_INSTR=32'h0.
  - typedef fetch_entry_t {inst, pc4} parametrised on XLEN via a localparam default.
  - Function clog2-safe count width.
- Sub-module fetch_fifo: synchronous FIFO, DEPTH entries, push/pop/flush, count output, registered head. The top holds PC, credit and drop logic.

Test Plan:
- Reset, zero-wait memory (gnt=1, rvalid one cycle after gnt), ready=1 → addrs 0x0,0x4,0x8 issued on consecutive cycles; outputs pc4=0x4,0x8,0xC in order, no gaps after fill.
- ready=0 for 10 cycles, DEPTH=4 → imem_req_o drops after 4 grants; ready=1 → the 4 instructions emerge unchanged, then fetch resumes at 0x10.
- Memory latency 3 with 2 outstanding, redirect to 0x100 → next 2 rvalid discarded; first output pc4=0x104 with the word from 0x100.
- redirect_i and rvalid in the same cycle with 1 outstanding → that response is dropped, drop_cnt=0, next output pc4 = target+4.
- Redirect to 0xFFFF_FFFC → fetch addrs 0xFFFF_FFFC, 0x0000_0000; pc4 outputs 0x0000_0000, 0x0000_0004.
- rst_i asserted with 3 outstanding and FIFO half full → next cycle inst_valid_o=0, imem_req_o=0, then the first request is to RESET_PC.
